control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: falling-edge Moore sequencer driving a 10-bit, four-register bus datapath.
// Define CTRL_EXEC_EDGE_EN to start instructions on a rising edge of EXEC instead of its level.
module control_unit (
    input  logic       CLKb,
    input  logic       Reset,
    input  logic [9:0] INST,
    input  logic       EXEC,
    output logic [9:0] IMM,
    output logic       ENW,
    output logic       Ext,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic [3:0] ALUcont,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       Done
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_CP  = 3'd1,
        OP_BIN = 3'd2,
        OP_UN  = 3'd3,
        OP_IMM = 3'd4,
        OP_NOP = 3'd5
    } op_e;

    step_e      step_q, step_d;
    logic [9:0] ir_q, ir_d;
    logic       trigger;
    op_e        op;

    logic [1:0] cls;
    logic [1:0] x_sel;
    logic [1:0] y_sel;
    logic [3:0] fn;
    logic [3:0] x_oh;
    logic [3:0] y_oh;

    assign cls   = ir_q[9:8];
    assign x_sel = ir_q[7:6];
    assign y_sel = ir_q[5:4];
    assign fn    = ir_q[3:0];
    assign x_oh  = 4'b0001 << x_sel;
    assign y_oh  = 4'b0001 << y_sel;

    // The immediate always reflects IR, so it reads zero out of reset.
    assign IMM = {4'b0000, ir_q[5:0]};

`ifdef CTRL_EXEC_EDGE_EN
    logic exec_q;

    always_ff @(negedge CLKb or posedge Reset) begin
        if (Reset) exec_q <= 1'b0;
        else       exec_q <= EXEC;
    end

    assign trigger = EXEC & ~exec_q;
`else
    assign trigger = EXEC;
`endif

    always_comb begin
        op = OP_NOP;
        case (cls)
            2'b10, 2'b11: op = OP_IMM;
            2'b01:        op = OP_NOP;
            default: begin
                case (fn)
                    4'b0000:                            op = OP_LD;
                    4'b0001:                            op = OP_CP;
                    4'b0100, 4'b0101:                   op = OP_UN;
                    4'b1100, 4'b1101, 4'b1110, 4'b1111: op = OP_NOP;
                    default:                            op = OP_BIN;
                endcase
            end
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ENW     = 1'b0;
        Ext     = 1'b0;
        Rin     = 4'b0000;
        Rout    = 4'b0000;
        ALUcont = 4'b0000;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        Done    = 1'b0;
        case (step_q)
            T1: begin
                case (op)
                    OP_LD: begin
                        Ext  = 1'b1;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_CP: begin
                        Rout = y_oh;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_BIN, OP_IMM: begin
                        Rout = x_oh;
                        Ain  = 1'b1;
                    end
                    OP_UN: begin
                        Rout    = y_oh;
                        Gin     = 1'b1;
                        ALUcont = fn;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                case (op)
                    OP_BIN: begin
                        Rout    = y_oh;
                        Gin     = 1'b1;
                        ALUcont = fn;
                    end
                    OP_IMM: begin
                        ENW     = 1'b1;
                        Gin     = 1'b1;
                        ALUcont = cls[0] ? 4'b0011 : 4'b0010;
                    end
                    OP_UN: begin
                        Gout = 1'b1;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                if (op == OP_BIN || op == OP_IMM) begin
                    Gout = 1'b1;
                    Rin  = x_oh;
                    Done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // IR only loads on a T0 trigger; INST and EXEC are ignored mid-instruction.
    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        if (Done) begin
            step_d = T0;
        end else begin
            case (step_q)
                T0: begin
                    if (trigger) begin
                        step_d = T1;
                        ir_d   = INST;
                    end
                end
                T1:      step_d = T2;
                T2:      step_d = T3;
                default: step_d = T0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(negedge CLKb or posedge Reset) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= 10'd0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

endmodule
